// File: rtl/led_fader.sv
// led_fader: per-channel PWM LED drive with linear fade ramps; gamma duty curve when LED_FADER_GAMMA_EN is defined.
// One clk from pwm_cnt to led_out, busy registered; no backpressure, led_in/brightness are consumed every cycle.
module led_fader #(
  parameter int LED       = 4,
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 390625
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LED-1:0]      led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [LED-1:0]      led_out,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP - 1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} ramp_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;
  logic                period_end;
  logic [LED-1:0]      mismatch;

  logic [PWM_BITS-1:0] target    [LED];
  logic [PWM_BITS-1:0] level     [LED];
  logic [PWM_BITS-1:0] duty      [LED];
  logic [PWM_BITS-1:0] duty_next [LED];
  ramp_t               state     [LED];

  assign step_tick  = (step_cnt == STEP_LAST);
  assign period_end = (pwm_cnt == PWM_MAX);

  // Ramp direction is re-derived every cycle so a retarget takes effect on the very next tick.
  always_comb begin
    for (int i = 0; i < LED; i++) begin
      target[i]   = led_in[i] ? brightness : '0;
      mismatch[i] = (level[i] != target[i]);
      if (level[i] < target[i])
        state[i] = RAMP_UP;
      else if (level[i] > target[i])
        state[i] = RAMP_DOWN;
      else
        state[i] = IDLE;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq [LED];

  always_comb begin
    for (int i = 0; i < LED; i++) begin
      level_sq[i]  = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
      duty_next[i] = (level[i] == PWM_MAX) ? PWM_MAX : PWM_BITS'(level_sq[i] >> PWM_BITS);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < LED; i++) begin
      duty_next[i] = level[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      led_out  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < LED; i++) begin
        level[i] <= '0;
        duty[i]  <= '0;
      end
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      busy     <= |mismatch;
      for (int i = 0; i < LED; i++) begin
        if (step_tick) begin
          case (state[i])
            RAMP_UP:   level[i] <= level[i] + 1'b1;
            RAMP_DOWN: level[i] <= level[i] - 1'b1;
            default:   level[i] <= level[i];
          endcase
        end
        // Shadow duty only changes at the period boundary, using the pre-step level.
        if (period_end)
          duty[i] <= duty_next[i];
        led_out[i] <= (duty[i] == PWM_MAX) || (pwm_cnt < duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader with PWM_BITS=4, FADE_STEP=4, LED=4.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_in;
  logic [3:0] brightness;
  logic [3:0] led_out;
  logic       busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int base   = 0;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] led;
    logic       bsy;
    bit         chk_led;
    bit         chk_busy;
  } exp_t;

  exp_t sb[$];

  led_fader #(.LED(4), .PWM_BITS(4), .FADE_STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .brightness (brightness),
    .led_out    (led_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dmap(input int l);
`ifdef LED_FADER_GAMMA_EN
    return (l == 15) ? 15 : (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  task automatic push(input string nm, input int c, input logic [3:0] l, input logic b,
                      input bit cl, input bit cb);
    exp_t e;
    e.name = nm; e.cyc = c; e.led = l; e.bsy = b; e.chk_led = cl; e.chk_busy = cb;
    sb.push_back(e);
  endtask

  // c0 is the cycle whose output reflects pwm_cnt==0; channel 0 high for d clocks.
  task automatic push_period(input string nm, input int c0, input int d, input logic b, input bit cb);
    for (int k = 0; k < 16; k++)
      push(nm, c0 + k, (d == 15 || k < d) ? 4'b0001 : 4'b0000, b, 1'b1, cb);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].chk_led) begin
          checks++;
          if (led_out !== sb[i].led) begin
            errors++;
            $display("FAIL %s cyc=%0d led_out=%b expected=%b", sb[i].name, cyc, led_out, sb[i].led);
          end
        end
        if (sb[i].chk_busy) begin
          checks++;
          if (busy !== sb[i].bsy) begin
            errors++;
            $display("FAIL %s cyc=%0d busy=%b expected=%b", sb[i].name, cyc, busy, sb[i].bsy);
          end
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1; led_in = 4'b0000; brightness = 4'd15;
    for (int c = 1; c <= 3; c++) push("reset", c, 4'b0000, 1'b0, 1'b1, 1'b1);
    goto(3);
    rst = 1'b0; base = 3;

    // Idle: dark and not busy.
    for (int n = 1; n <= 200; n++) push("idle", base + n, 4'b0000, 1'b0, 1'b1, 1'b1);

    // Full-scale ramp up on channel 0.
    goto(base + 200);
    push("ramp_start", base + 201, 4'b0000, 1'b1, 1'b1, 1'b1);
    push("ramp_busy",  base + 260, 4'b0000, 1'b1, 1'b0, 1'b1);
    push("ramp_done",  base + 261, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int n = 273; n <= 304; n++) push("full_on", base + n, 4'b0001, 1'b0, 1'b1, 1'b1);
    led_in = 4'b0001;

    // Fade down to a steady level 6.
    goto(base + 304);
    push("to6_busy", base + 340, 4'b0000, 1'b1, 1'b0, 1'b1);
    push("to6_done", base + 341, 4'b0000, 1'b0, 1'b0, 1'b1);
    push_period("pwm6_a", base + 353, dmap(6), 1'b0, 1'b1);
    push_period("pwm6_b", base + 369, dmap(6), 1'b0, 1'b1);
    brightness = 4'd6;

    // Up to 8, then fade out to dark.
    goto(base + 384);
    push("to8_busy", base + 385, 4'b0000, 1'b1, 1'b0, 1'b1);
    push("to8_done", base + 393, 4'b0000, 1'b0, 1'b0, 1'b1);
    brightness = 4'd8;
    goto(base + 400);
    push_period("lvl8",   base + 401, dmap(8), 1'b1, 1'b1);
    push_period("fade5",  base + 417, dmap(5), 1'b1, 1'b1);
    push_period("fade1",  base + 433, dmap(1), 1'b0, 1'b1);
    push_period("dark_a", base + 449, 0, 1'b0, 1'b1);
    push_period("dark_b", base + 465, 0, 1'b0, 1'b1);
    led_in = 4'b0000;

    // Reset in the middle of a ramp at level 5.
    goto(base + 480);
    push("rampup2", base + 481, 4'b0000, 1'b1, 1'b0, 1'b1);
    led_in = 4'b0001; brightness = 4'd15;
    goto(base + 500);
    push("rst_mid_a", base + 501, 4'b0000, 1'b0, 1'b1, 1'b1);
    push("rst_mid_b", base + 502, 4'b0000, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    goto(base + 502);
    rst = 1'b0; base = base + 502;
    push("restart", base + 1, 4'b0000, 1'b1, 1'b1, 1'b1);
    push_period("restart3", base + 17, dmap(3), 1'b1, 1'b1);
    push_period("restart7", base + 33, dmap(7), 1'b1, 1'b1);
    push("restart_busy", base + 60, 4'b0000, 1'b1, 1'b0, 1'b1);
    push("restart_done", base + 61, 4'b0000, 1'b0, 1'b0, 1'b1);

    goto(base + 70);
    @(negedge clk);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d never sampled (now %0d)", sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
